// File: rtl/tlcd_pkg.sv
// Shared definitions for the text-LCD blocks: line geometry, the blank line
// pattern and the scheduler state encoding.
package tlcd_pkg;

  localparam int NUM_REQ_MAX = 4;
  localparam int IDX_W       = 2;
  localparam int CNT_W       = 17;
  localparam int LINE_CHARS  = 16;
  localparam int LINE_BITS   = LINE_CHARS * 8;

  localparam logic [LINE_BITS-1:0] SPACE_LINE = {LINE_CHARS{8'h20}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULSE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/tlcd_rr_arb.sv
// Combinational round-robin picker: the requester right after last_grant has
// the highest priority, last_grant itself has the lowest.
module tlcd_rr_arb
  import tlcd_pkg::*;
(
  input  logic [NUM_REQ_MAX-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic                   valid,
  output logic [IDX_W-1:0]       winner
);

  logic [IDX_W-1:0] cand;

  // Walk from the lowest priority offset up so the nearest requester wins.
  always_comb begin
    valid  = |req;
    winner = last_grant;
    cand   = last_grant;
    for (int k = NUM_REQ_MAX; k >= 1; k--) begin
      cand = last_grant + IDX_W'(k);
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/tlcd_scheduler.sv
// Time-shares one tlcd_controller between four requesters: grant, latch the
// two text lines, pulse ENABLE, wait out the fixed update window, then ACK.
module tlcd_scheduler
  import tlcd_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ENABLE_HIGH   = 4,
  parameter int UPDATE_CYCLES = 65000
) (
  input  logic                           CLK,
  input  logic                           RESETN,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ*LINE_BITS-1:0]   TEXT_UPPER_IN,
  input  logic [NUM_REQ*LINE_BITS-1:0]   TEXT_LOWER_IN,
  output logic [NUM_REQ-1:0]             ACK,
  output logic                           BUSY,
  output logic [IDX_W-1:0]               GRANT_IDX,
  output logic                           TLCD_ENABLE,
  output logic [LINE_BITS-1:0]           TEXT_STRING_UPPER,
  output logic [LINE_BITS-1:0]           TEXT_STRING_LOWER
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(ENABLE_HIGH - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(UPDATE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic                   enable_q, enable_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic [LINE_BITS-1:0]   upper_q, upper_d;
  logic [LINE_BITS-1:0]   lower_q, lower_d;

  logic                   arb_valid;
  logic [IDX_W-1:0]       arb_winner;

  tlcd_rr_arb u_arb (
    .req        (REQ),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  always_ff @(posedge CLK) begin
    if (RESETN) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_idx_q  <= '0;
      enable_q     <= 1'b0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
      upper_q      <= SPACE_LINE;
      lower_q      <= SPACE_LINE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_idx_q  <= grant_idx_d;
      enable_q     <= enable_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      upper_q      <= upper_d;
      lower_q      <= lower_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_valid) state_d = ST_PULSE;
      ST_PULSE: if (cnt_q == PULSE_LAST) state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == WAIT_LAST) state_d = ST_ACK;
      ST_ACK:   state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_idx_d  = grant_idx_q;
    enable_d     = enable_q;
    ack_d        = '0;
    upper_d      = upper_q;
    lower_d      = lower_q;
    busy_d       = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          upper_d     = TEXT_UPPER_IN[int'(arb_winner)*LINE_BITS +: LINE_BITS];
          lower_d     = TEXT_LOWER_IN[int'(arb_winner)*LINE_BITS +: LINE_BITS];
          grant_idx_d = arb_winner;
          enable_d    = 1'b1;
          cnt_d       = '0;
        end
      end
      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          enable_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          ack_d[grant_idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        last_grant_d = grant_idx_q;
      end
      default: ;
    endcase
  end

  assign ACK               = ack_q;
  assign BUSY              = busy_q;
  assign GRANT_IDX         = grant_idx_q;
  assign TLCD_ENABLE       = enable_q;
  assign TEXT_STRING_UPPER = upper_q;
  assign TEXT_STRING_LOWER = lower_q;

endmodule

// File: tb/tb_tlcd_scheduler.sv
// Directed bench for tlcd_scheduler with a short update window (3 + 20 cycles).
module tb_tlcd_scheduler;

  localparam int EH = 3;
  localparam int UC = 20;
  localparam int ACK_LAT = EH + UC;

  logic         CLK = 1'b0;
  logic         RESETN = 1'b1;
  logic [3:0]   REQ = 4'b0000;
  logic [511:0] TEXT_UPPER_IN = '0;
  logic [511:0] TEXT_LOWER_IN = '0;
  logic [3:0]   ACK;
  logic         BUSY;
  logic [1:0]   GRANT_IDX;
  logic         TLCD_ENABLE;
  logic [127:0] TEXT_STRING_UPPER;
  logic [127:0] TEXT_STRING_LOWER;

  logic [127:0] up_txt [4];
  logic [127:0] lo_txt [4];
  logic [127:0] spaces;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  tlcd_scheduler #(
    .NUM_REQ       (4),
    .ENABLE_HIGH   (EH),
    .UPDATE_CYCLES (UC)
  ) dut (
    .CLK               (CLK),
    .RESETN            (RESETN),
    .REQ               (REQ),
    .TEXT_UPPER_IN     (TEXT_UPPER_IN),
    .TEXT_LOWER_IN     (TEXT_LOWER_IN),
    .ACK               (ACK),
    .BUSY              (BUSY),
    .GRANT_IDX         (GRANT_IDX),
    .TLCD_ENABLE       (TLCD_ENABLE),
    .TEXT_STRING_UPPER (TEXT_STRING_UPPER),
    .TEXT_STRING_LOWER (TEXT_STRING_LOWER)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic pack_text();
    for (int i = 0; i < 4; i++) begin
      TEXT_UPPER_IN[i*128 +: 128] = up_txt[i];
      TEXT_LOWER_IN[i*128 +: 128] = lo_txt[i];
    end
  endtask

  task automatic apply_reset();
    RESETN = 1'b1;
    REQ    = 4'b0000;
    tick();
    tick();
    RESETN = 1'b0;
  endtask

  // Follows one update from grant to ACK; optionally drops REQ and rewrites
  // the requester's text mid-window to prove the update is not aborted.
  task automatic serve(input logic [1:0] idx, input logic [127:0] exp_up,
                       input logic [127:0] exp_lo, input bit abort_free);
    int n;
    int t0;
    logic [3:0] one;
    one = 4'b0001;
    n = 0;
    while (!TLCD_ENABLE && n < 60) begin
      tick();
      n++;
    end
    if (!TLCD_ENABLE) begin
      check_val("grant_timeout", 128'(TLCD_ENABLE), 128'(1));
      return;
    end
    t0 = cyc;
    check_val("grant_idx", 128'(GRANT_IDX), 128'(idx));
    check_val("busy_at_grant", 128'(BUSY), 128'(1));
    check_val("upper_latch", TEXT_STRING_UPPER, exp_up);
    check_val("lower_latch", TEXT_STRING_LOWER, exp_lo);
    n = 0;
    while (TLCD_ENABLE && n < 10) begin
      n++;
      tick();
    end
    check_val("enable_width", 128'(n), 128'(EH));
    if (abort_free) begin
      repeat (4) tick();
      REQ[idx] = 1'b0;
      up_txt[idx] = "CHANGED LATE    ";
      pack_text();
      tick();
      check_val("upper_held", TEXT_STRING_UPPER, exp_up);
    end
    n = 0;
    while (ACK == 4'b0000 && n < 60) begin
      tick();
      n++;
    end
    check_val("ack_latency", 128'(cyc - t0), 128'(ACK_LAT));
    check_val("ack_value", 128'(ACK), 128'(one << idx));
    $display("update: grant=%0d ack=%b after %0d cycles", GRANT_IDX, ACK, cyc - t0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    spaces    = {16{8'h20}};
    up_txt[0] = "GAME LOGIC 0    ";
    up_txt[1] = "SCORE 0123      ";
    up_txt[2] = "TIMER 09:59     ";
    up_txt[3] = "STATUS READY    ";
    lo_txt[0] = "game line two   ";
    lo_txt[1] = "score line two  ";
    lo_txt[2] = "timer line two  ";
    lo_txt[3] = "status line two ";
    pack_text();

    // Reset state
    apply_reset();
    check_val("rst_enable", 128'(TLCD_ENABLE), 128'(0));
    check_val("rst_ack", 128'(ACK), 128'(0));
    check_val("rst_busy", 128'(BUSY), 128'(0));
    check_val("rst_grant", 128'(GRANT_IDX), 128'(0));
    check_val("rst_upper", TEXT_STRING_UPPER, spaces);
    check_val("rst_lower", TEXT_STRING_LOWER, spaces);

    // Single request with grant latency and post-ACK BUSY timing
    REQ = 4'b0010;
    tick();
    check_val("grant_latency", 128'(TLCD_ENABLE), 128'(1));
    serve(2'd1, up_txt[1], lo_txt[1], 1'b0);
    REQ = 4'b0000;
    tick();
    check_val("ack_one_cycle", 128'(ACK), 128'(0));
    check_val("busy_in_gap", 128'(BUSY), 128'(1));
    tick();
    check_val("busy_after_gap", 128'(BUSY), 128'(0));

    // Contention: all four request, each drops after its ACK
    apply_reset();
    REQ = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      serve(2'(i), up_txt[i], lo_txt[i], 1'b0);
      REQ[i] = 1'b0;
    end
    repeat (4) tick();
    check_val("contention_idle", 128'(BUSY), 128'(0));

    // Fairness: requester 0 keeps coming back while requester 2 waits
    apply_reset();
    REQ = 4'b0101;
    for (int r = 0; r < 2; r++) begin
      serve(2'd0, up_txt[0], lo_txt[0], 1'b0);
      REQ[0] = 1'b0;
      tick();
      REQ[0] = 1'b1;
      serve(2'd2, up_txt[2], lo_txt[2], 1'b0);
    end
    REQ = 4'b0000;

    // Abort-free: REQ dropped and text rewritten during WAIT
    apply_reset();
    REQ = 4'b0010;
    serve(2'd1, up_txt[1], lo_txt[1], 1'b1);
    REQ = 4'b0000;
    up_txt[1] = "SCORE 0123      ";
    pack_text();

    // Reset in the middle of WAIT, then a normal grant
    apply_reset();
    REQ = 4'b0001;
    tick();
    check_val("pre_reset_grant", 128'(TLCD_ENABLE), 128'(1));
    repeat (EH + 10) tick();
    RESETN = 1'b1;
    REQ = 4'b0000;
    tick();
    RESETN = 1'b0;
    check_val("midrst_busy", 128'(BUSY), 128'(0));
    check_val("midrst_ack", 128'(ACK), 128'(0));
    check_val("midrst_enable", 128'(TLCD_ENABLE), 128'(0));
    check_val("midrst_upper", TEXT_STRING_UPPER, spaces);
    begin
      int ack_seen;
      ack_seen = 0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (ACK != 4'b0000) ack_seen++;
      end
      check_val("midrst_no_ack", 128'(ack_seen), 128'(0));
    end
    REQ = 4'b0001;
    serve(2'd0, up_txt[0], lo_txt[0], 1'b0);
    REQ = 4'b0000;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
